// File: rtl/br_issue_sched.sv
// br_issue_sched: branch-class issue queue with oldest-ready select,
// wakeup from two writeback ports and mispredict kill of younger entries.
// Ports: clk/reset (async, active high); disp_* dispatch in (valid/ready,
// payload, two source pregs + ready bits); wb_valid/wb_preg0/wb_preg1 wakeup;
// fu_ready + issue_* select out; mispredict/mispredict_tag/curr_rob_tag flush;
// occupancy = valid entry count.
// Optional macro BR_SCHED_PERF_EN adds saturating counters perf_issued,
// perf_killed and perf_full_cycles.

package br_sched_pkg;
  localparam int BR_TAG_W  = 5;
  localparam int BR_PREG_W = 7;

  typedef struct packed {
    logic [BR_TAG_W-1:0]  rob_index;
    logic [6:0]           opcode;
    logic [2:0]           func3;
    logic [31:0]          pc;
    logic [31:0]          imm;
    logic [BR_PREG_W-1:0] pd;
  } rs_data;

  typedef enum logic [1:0] {
    S_FREE,
    S_WAIT,
    S_READY
  } ent_state_e;
endpackage

module br_issue_sched
  import br_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = BR_TAG_W,
  parameter int PREG_W   = BR_PREG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    disp_valid,
  output logic                    disp_ready,
  input  rs_data                  disp_data,
  input  logic [PREG_W-1:0]       disp_ps1,
  input  logic                    disp_ps1_rdy,
  input  logic [PREG_W-1:0]       disp_ps2,
  input  logic                    disp_ps2_rdy,
  input  logic [1:0]              wb_valid,
  input  logic [PREG_W-1:0]       wb_preg0,
  input  logic [PREG_W-1:0]       wb_preg1,
  input  logic                    fu_ready,
  output logic                    issue_valid,
  output rs_data                  issue_data,
  output logic [PREG_W-1:0]       issue_ps1,
  output logic [PREG_W-1:0]       issue_ps2,
  input  logic                    mispredict,
  input  logic [TAG_W-1:0]        mispredict_tag,
  input  logic [TAG_W-1:0]        curr_rob_tag,
  output logic [$clog2(DEPTH):0]  occupancy
`ifdef BR_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_issued,
  output logic [31:0]             perf_killed,
  output logic [31:0]             perf_full_cycles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  ent_state_e        state_q [DEPTH];
  rs_data            data_q  [DEPTH];
  logic [PREG_W-1:0] ps1_q   [DEPTH];
  logic [PREG_W-1:0] ps2_q   [DEPTH];
  logic [DEPTH-1:0]  rdy1_q;
  logic [DEPTH-1:0]  rdy2_q;
  // age_q[j][i] = 1: entry j was dispatched before entry i
  logic [DEPTH-1:0]  age_q   [DEPTH];
  logic [DEPTH-1:0]  age_d   [DEPTH];

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  kill;
  logic [DEPTH-1:0]  wake1;
  logic [DEPTH-1:0]  wake2;
  logic [DEPTH-1:0]  sel_oh;
  logic [DEPTH-1:0]  alloc_oh;
  logic              older;
  logic              disp_fire;
  logic              issue_fire;
  logic              d_rdy1;
  logic              d_rdy2;
  logic [TAG_W-1:0]  d_t;
  logic [CW-1:0]     occ;

  function automatic logic wb_hit(input logic [PREG_W-1:0] p);
    return (wb_valid[0] && (wb_preg0 == p)) ||
           (wb_valid[1] && (wb_preg1 == p));
  endfunction

  // (a - b) mod ROB_SIZE; both tags are below ROB_SIZE
  function automatic logic [TAG_W-1:0] tag_dist(
    input logic [TAG_W-1:0] a,
    input logic [TAG_W-1:0] b
  );
    logic [TAG_W:0] d;
    d = {1'b0, a} + (TAG_W+1)'(ROB_SIZE) - {1'b0, b};
    if (d >= (TAG_W+1)'(ROB_SIZE))
      d = d - (TAG_W+1)'(ROB_SIZE);
    return d[TAG_W-1:0];
  endfunction

  always_comb begin
    valid = '0;
    ready = '0;
    kill  = '0;
    wake1 = '0;
    wake2 = '0;
    occ   = '0;
    d_t   = tag_dist(curr_rob_tag, mispredict_tag);
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = state_q[i] != S_FREE;
      ready[i] = state_q[i] == S_READY;
      wake1[i] = rdy1_q[i] | wb_hit(ps1_q[i]);
      wake2[i] = rdy2_q[i] | wb_hit(ps2_q[i]);
      occ      = occ + CW'(valid[i]);
      kill[i]  = mispredict && valid[i] &&
                 (tag_dist(data_q[i].rob_index, mispredict_tag) != '0) &&
                 (tag_dist(data_q[i].rob_index, mispredict_tag) < d_t);
    end
  end

  always_comb begin
    alloc_oh = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i])
        alloc_oh = DEPTH'(1) << i;
  end

  // an entry is selected when no other ready entry is older
  always_comb begin
    sel_oh = '0;
    older  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && age_q[j][i])
          older = 1'b1;
      sel_oh[i] = ready[i] & ~older;
    end
  end

  always_comb begin
    issue_valid = (|ready) & ~mispredict;
    issue_data  = '0;
    issue_ps1   = '0;
    issue_ps2   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel_oh[i] && !mispredict) begin
        issue_data = data_q[i];
        issue_ps1  = ps1_q[i];
        issue_ps2  = ps2_q[i];
      end
  end

  assign occupancy  = occ;
  assign disp_ready = (occ < CW'(DEPTH)) & ~mispredict;
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_fire = issue_valid & fu_ready;
  assign d_rdy1     = disp_ps1_rdy | wb_hit(disp_ps1);
  assign d_rdy2     = disp_ps2_rdy | wb_hit(disp_ps2);

  // new entry is younger than every live entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      for (int j = 0; j < DEPTH; j++)
        if (disp_fire && alloc_oh[j])
          age_d[i][j] = valid[i];
      if (disp_fire && alloc_oh[i])
        age_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy1_q <= '0;
      rdy2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= S_FREE;
        data_q[i]  <= '0;
        ps1_q[i]   <= '0;
        ps2_q[i]   <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= age_d[i];
        if (kill[i] || (issue_fire && sel_oh[i])) begin
          state_q[i] <= S_FREE;
        end else if (disp_fire && alloc_oh[i]) begin
          data_q[i]  <= disp_data;
          ps1_q[i]   <= disp_ps1;
          ps2_q[i]   <= disp_ps2;
          rdy1_q[i]  <= d_rdy1;
          rdy2_q[i]  <= d_rdy2;
          state_q[i] <= (d_rdy1 && d_rdy2) ? S_READY : S_WAIT;
        end else if (state_q[i] == S_WAIT) begin
          rdy1_q[i] <= wake1[i];
          rdy2_q[i] <= wake2[i];
          if (wake1[i] && wake2[i])
            state_q[i] <= S_READY;
        end
      end
    end
  end

`ifdef BR_SCHED_PERF_EN
  logic [CW-1:0] n_kill;

  always_comb begin
    n_kill = '0;
    for (int i = 0; i < DEPTH; i++)
      n_kill = n_kill + CW'(kill[i]);
  end

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued      <= '0;
      perf_killed      <= '0;
      perf_full_cycles <= '0;
    end else begin
      perf_issued      <= sat_add(perf_issued, 32'(issue_fire));
      perf_killed      <= sat_add(perf_killed, 32'(n_kill));
      perf_full_cycles <= sat_add(perf_full_cycles,
                            32'(disp_valid && (occ == CW'(DEPTH))));
    end
  end
`endif

endmodule

// File: doc/br_issue_sched.md
Name: br_issue_sched

Overview:
- Branch-class issue scheduler: a small reservation queue between rename/dispatch and the branch functional unit.
- Buffers JALR/BNE micro-ops until their source physical registers are ready.
- Each cycle, selects the oldest ready entry and hands it to the branch FU.
- On a branch mispredict, kills every buffered entry younger than the mispredicting ROB tag.

Parameters:
DEPTH, 4, number of scheduler entries (power of two, 2..8)
ROB_SIZE, 16, ROB entries; tags wrap modulo ROB_SIZE
TAG_W, 5, ROB tag width
PREG_W, 7, physical register index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
disp_valid  in  1  dispatch request
disp_ready  out  1  free entry available and no flush this cycle
disp_data  in  rs_data  micro-op payload (carries rob_index, Opcode, func3, pc, imm, pd)
disp_ps1  in  PREG_W  source 1 physical reg
disp_ps1_rdy  in  1  source 1 ready at dispatch
disp_ps2  in  PREG_W  source 2 physical reg
disp_ps2_rdy  in  1  source 2 ready at dispatch
wb_valid  in  2  writeback broadcast valid, two ports
wb_preg0  in  PREG_W  port 0 destination preg
wb_preg1  in  PREG_W  port 1 destination preg
fu_ready  in  1  branch FU accepts (fu_b_ready)
issue_valid  out  1  issue_data valid
issue_data  out  rs_data  selected micro-op
issue_ps1  out  PREG_W  PRF read address 1
issue_ps2  out  PREG_W  PRF read address 2
mispredict  in  1  flush pulse from branch FU/ROB
mispredict_tag  in  TAG_W  ROB tag of mispredicting branch
curr_rob_tag  in  TAG_W  ROB tail (next tag to allocate)
occupancy  out  $clog2(DEPTH)+1  valid entry count

Behaviour:
- Reset (async): all entries FREE; age order cleared; issue_valid=0; issue_* outputs=0; disp_ready=1; occupancy=0.
- Entry state machine:
  - FREE->WAIT on dispatch when a source is not ready.
  - FREE->READY when both sources are ready, or become ready via a same-cycle wakeup.
  - WAIT->READY when the last pending source matches a valid wb port.
  - READY->FREE on issue handshake.
  - Any state->FREE on flush kill.
- Dispatch: accepted at the posedge when disp_valid & disp_ready. The entry is written into the lowest-index FREE slot and marked youngest in the age matrix.
- disp_ready = (occupancy<DEPTH) & ~mispredict. It does not depend on a same-cycle issue freeing a slot.
- Wakeup: compare each WAIT source against wb_preg0/wb_preg1 gated by wb_valid. The dispatch path applies the same compare, so a source written back in the dispatch cycle is ready.
- Select (combinational): issue_valid=1 iff any entry is READY and mispredict=0. Selection is the oldest READY entry by dispatch order. issue_data, issue_ps1 and issue_ps2 come from that entry.
- Issue handshake: issue_valid & fu_ready at the posedge frees the entry. If fu_ready=0, the selection is held; an older entry becoming ready may displace it.
- Minimum latency: dispatch with both sources ready at edge N gives issue_valid high in cycle N+1.
- Flush:
  - While mispredict=1, compute d_e=(rob_index-mispredict_tag) mod ROB_SIZE and d_t=(curr_rob_tag-mispredict_tag) mod ROB_SIZE.
  - An entry is killed at the edge iff 0<d_e<d_t. The mispredicting tag itself (d_e=0) and older entries survive.
  - No dispatch and no issue in the flush cycle.
  - Age order of survivors is preserved.
- Simultaneous events:
  - Issue and dispatch in one cycle: both happen; occupancy is unchanged.
  - Wakeup and flush on the same entry: the kill wins.
- occupancy is updated at every edge: +1 on accepted dispatch, -1 on issue, -k for k killed entries.
- Full: DEPTH entries valid -> disp_ready=0, no overwrite. Empty -> issue_valid=0.
- ROB tag wrap is handled solely by modulo-ROB_SIZE arithmetic computed in TAG_W bits. Examples: mispredict_tag=15, curr_rob_tag=2 kills tags 0 and 1.
- Reset asserted mid-operation clears all state immediately; outputs return to reset values asynchronously.

Optional Feature:
BR_SCHED_PERF_EN:
- When defined, adds 32-bit outputs perf_issued, perf_killed and perf_full_cycles. These count issue handshakes, flush-killed entries, and cycles with disp_valid & occupancy==DEPTH respectively.
- The counters reset to 0, saturate at all-ones, and are not cleared by mispredict.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then dispatch BNE rob 3, both sources ready -> issue_valid=1 next cycle, issue_data.rob_index=3; with fu_ready=1, occupancy 1->0.
- Dispatch rob 4 (ps1=12 not ready), then rob 5 (ready) -> rob 5 issues first. wb_valid=01, wb_preg0=12 -> rob 4 issues the following cycle.
- Fill 4 entries with fu_ready=0 -> disp_ready=0, occupancy=4. A fifth disp_valid is ignored; perf_full_cycles increments when BR_SCHED_PERF_EN is defined.
- Entries rob 14, 15, 0, 1; mispredict=1, mispredict_tag=15, curr_rob_tag=2 -> 0 and 1 killed, 14 and 15 kept, occupancy=2, issue_valid=0 that cycle.
- Dispatch with ps2=9 not ready and wb_valid=10, wb_preg1=9 in the same cycle -> entry READY, issues next cycle.
- Assert reset mid-stream with 3 entries valid -> issue_valid=0, occupancy=0, disp_ready=1 immediately, before the next clock edge.
